// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART flag controller.
package spart_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam logic [BYTE_W-1:0] STOP_BYTE_DEFAULT = 8'h1B;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_DRAIN     = 2'd3
  } tx_state_t;
endpackage

// File: rtl/spart_flag_ctrl_if.sv
// UART byte side plus CPU flag side of spart_flag_ctrl.
// SPART_OVERRUN_CNT_EN adds the overrun_cnt signal.
interface spart_flag_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        received_data;
  logic [31:0] rx_word;
  logic        received_ak;
  logic        stop_data;
  logic        stop_ak;
  logic        send_data;
  logic [31:0] tx_word;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        tx_active;
  logic        overrun;
`ifdef SPART_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  modport slave (
    input  rx_valid, rx_byte, received_ak, stop_ak, send_data, tx_word, tx_busy,
    output received_data, rx_word, stop_data, tx_start, tx_byte, tx_active, overrun
`ifdef SPART_OVERRUN_CNT_EN
    , overrun_cnt
`endif
  );

  modport master (
    output rx_valid, rx_byte, received_ak, stop_ak, send_data, tx_word, tx_busy,
    input  received_data, rx_word, stop_data, tx_start, tx_byte, tx_active, overrun
`ifdef SPART_OVERRUN_CNT_EN
    , overrun_cnt
`endif
  );
endinterface

// File: rtl/spart_flag_ctrl_rise_edge.sv
// Registered rising-edge detector: rise_o = in_i & ~in_q.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic rise_o
);
  logic in_q, in_d;

  always_comb in_d = in_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in_d;

  assign rise_o = in_i & ~in_q;
endmodule

// File: rtl/spart_flag_ctrl.sv
// SPART-side CPU flag handshake: RX word assembly, stop detection, TX word serializer.
// Optional SPART_OVERRUN_CNT_EN adds a saturating dropped-word counter.
module spart_flag_ctrl
  import spart_pkg::*;
#(
  parameter logic [BYTE_W-1:0] STOP_BYTE = STOP_BYTE_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  spart_flag_ctrl_if.slave bus
);
  localparam int NUM_EDGES = 3;

  logic [NUM_EDGES-1:0] lvl, rise;
  logic                 rak_rise, sak_rise, send_rise;

  assign lvl = {bus.send_data, bus.stop_ak, bus.received_ak};

  for (genvar i = 0; i < NUM_EDGES; i++) begin : g_edge
    rise_edge u_rise (.clk(clk), .rst_n(rst_n), .in_i(lvl[i]), .rise_o(rise[i]));
  end

  assign rak_rise  = rise[0];
  assign sak_rise  = rise[1];
  assign send_rise = rise[2];

  // RX side
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         partial_q, partial_d;
  logic [WORD_W-1:0]   rx_word_q, rx_word_d;
  logic                received_data_q, received_data_d;
  logic                stop_data_q, stop_data_d;
  logic                overrun_q, overrun_d;
  logic                stop_hit, data_in, word_done, accept, drop;
`ifdef SPART_OVERRUN_CNT_EN
  logic [7:0]          ovr_cnt_q, ovr_cnt_d;
`endif

  always_comb begin
    byte_cnt_d      = byte_cnt_q;
    partial_d       = partial_q;
    rx_word_d       = rx_word_q;
    received_data_d = received_data_q;
    stop_data_d     = stop_data_q;
    overrun_d       = overrun_q;

    stop_hit  = bus.rx_valid && (byte_cnt_q == 2'd0) && (bus.rx_byte == STOP_BYTE);
    data_in   = bus.rx_valid && !stop_hit;
    word_done = data_in && (byte_cnt_q == 2'd3);
    // An ack edge in the completion cycle frees the slot, so the new word is taken.
    accept    = word_done && (!received_data_q || rak_rise);
    drop      = word_done && !accept;

    if (data_in) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    partial_d[7:0]   = bus.rx_byte;
        2'd1:    partial_d[15:8]  = bus.rx_byte;
        2'd2:    partial_d[23:16] = bus.rx_byte;
        default: partial_d        = partial_q;
      endcase
    end

    if (accept)        begin rx_word_d = {bus.rx_byte, partial_q}; received_data_d = 1'b1; end
    else if (rak_rise) received_data_d = 1'b0;

    if (stop_hit)      stop_data_d = 1'b1;
    else if (sak_rise) stop_data_d = 1'b0;

    if (drop)          overrun_d = 1'b1;
    else if (sak_rise) overrun_d = 1'b0;
  end

`ifdef SPART_OVERRUN_CNT_EN
  always_comb begin
    ovr_cnt_d = sak_rise ? 8'd0 : ovr_cnt_q;
    if (drop && ovr_cnt_d != 8'hFF) ovr_cnt_d = ovr_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovr_cnt_q <= 8'd0;
    else        ovr_cnt_q <= ovr_cnt_d;

  assign bus.overrun_cnt = ovr_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byte_cnt_q      <= 2'd0;
      partial_q       <= '0;
      rx_word_q       <= '0;
      received_data_q <= 1'b0;
      stop_data_q     <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      byte_cnt_q      <= byte_cnt_d;
      partial_q       <= partial_d;
      rx_word_q       <= rx_word_d;
      received_data_q <= received_data_d;
      stop_data_q     <= stop_data_d;
      overrun_q       <= overrun_d;
    end

  // TX side
  tx_state_t          state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    case (state_q)
      TX_IDLE:
        if (send_rise) begin
          word_d  = bus.tx_word;
          idx_d   = 2'd0;
          state_d = TX_SEND;
        end
      TX_SEND:
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = word_q[BYTE_W*idx_q +: BYTE_W];
          state_d    = TX_WAIT_BUSY;
        end
      TX_WAIT_BUSY:
        if (bus.tx_busy) state_d = TX_DRAIN;
      TX_DRAIN:
        if (!bus.tx_busy) begin
          if (idx_q == 2'(BYTES_PER_WORD - 1)) state_d = TX_IDLE;
          else begin
            idx_d   = idx_q + 2'd1;
            state_d = TX_SEND;
          end
        end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      idx_q      <= 2'd0;
      word_q     <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
    end

  assign bus.received_data = received_data_q;
  assign bus.rx_word       = rx_word_q;
  assign bus.stop_data     = stop_data_q;
  assign bus.overrun       = overrun_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_byte       = tx_byte_q;
  assign bus.tx_active     = (state_q != TX_IDLE);
endmodule

// File: tb/tb_spart_flag_ctrl.sv
// Scoreboard bench for spart_flag_ctrl: expected RX words / TX bytes queued, monitor compares.
module tb_spart_flag_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spart_flag_ctrl_if bus();
  spart_flag_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;
  int ntx = 0;
  logic [31:0] rx_q[$];
  logic [7:0]  tx_q[$];
  logic rd_prev = 1'b0;
  int busy_cnt;

  // UART TX model: busy for 10 cycles after each start strobe
  always @(posedge clk or negedge rst_n)
    if (!rst_n)            busy_cnt <= 0;
    else if (bus.tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign bus.tx_busy = (busy_cnt != 0);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        ntx++;
        if (tx_q.size() == 0) begin
          checks++;
          $display("FAIL tx_spurious: got tx_start with byte %h expected no start", bus.tx_byte);
        end else check("tx_byte", bus.tx_byte, tx_q.pop_front());
      end
      if (bus.received_data && !rd_prev) begin
        if (rx_q.size() == 0) begin
          checks++;
          $display("FAIL rx_spurious: got word %h expected no new word", bus.rx_word);
        end else check("rx_word", bus.rx_word, rx_q.pop_front());
      end
    end
    rd_prev = bus.received_data;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1; bus.rx_byte = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.tx_active && n < budget) begin step(); n++; end
    check("tx_done_in_budget", bus.tx_active, 1'b0);
  endtask

  initial begin
    bus.rx_valid = 0; bus.rx_byte = 0; bus.received_ak = 0; bus.stop_ak = 0;
    bus.send_data = 0; bus.tx_word = 0;
    repeat (3) step();
    check("rst_received_data", bus.received_data, 0);
    check("rst_rx_word", bus.rx_word, 0);
    check("rst_stop_data", bus.stop_data, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_active", bus.tx_active, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    step();

    // basic little-endian assembly
    rx_q.push_back(32'h44332211);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("rd_after_4th", bus.received_data, 1);

    // held ack clears once; word completing during hold stays flagged
    bus.received_ak = 1'b1;
    step();
    check("rd_cleared_by_ak", bus.received_data, 0);
    rx_q.push_back(32'h88776655);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check("rd_during_hold", bus.received_data, 1);
    bus.received_ak = 1'b0;
    step();
    check("rd_after_release", bus.received_data, 1);

    // second word without ack is dropped
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("overrun_set", bus.overrun, 1);
    check("rx_word_kept", bus.rx_word, 32'h88776655);
`ifdef SPART_OVERRUN_CNT_EN
    check("overrun_cnt_1", bus.overrun_cnt, 8'd1);
`endif

    // ack edge in the completion cycle: set wins, word updated
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    bus.received_ak = 1'b1;
    send_byte(8'hA4);
    check("rd_set_wins", bus.received_data, 1);
    check("rx_word_same_cycle", bus.rx_word, 32'hA4A3A2A1);
`ifdef SPART_OVERRUN_CNT_EN
    check("overrun_cnt_still_1", bus.overrun_cnt, 8'd1);
`endif
    bus.received_ak = 1'b0; step();
    bus.received_ak = 1'b1; step();
    check("rd_cleared_2", bus.received_data, 0);
    bus.received_ak = 1'b0;

    // stop byte at boundary vs. inside a word
    send_byte(8'h1B);
    check("stop_set", bus.stop_data, 1);
    rx_q.push_back(32'h401B2010);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h1B); send_byte(8'h40);
    check("rx_word_with_1b", bus.rx_word, 32'h401B2010);
    bus.stop_ak = 1'b1; step();
    check("stop_cleared", bus.stop_data, 0);
    check("overrun_cleared", bus.overrun, 0);
`ifdef SPART_OVERRUN_CNT_EN
    check("overrun_cnt_cleared", bus.overrun_cnt, 8'd0);
`endif
    bus.stop_ak = 1'b0; step();
    bus.stop_ak = 1'b1;
    send_byte(8'h1B);
    check("stop_set_wins", bus.stop_data, 1);
    bus.stop_ak = 1'b0; step();
    bus.stop_ak = 1'b1; step();
    check("stop_cleared_2", bus.stop_data, 0);
    bus.stop_ak = 1'b0;
    bus.received_ak = 1'b1; step();
    bus.received_ak = 1'b0; step();

    // TX serialization with an ignored mid-transfer request
    bus.tx_word = 32'hDEADBEEF;
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE); tx_q.push_back(8'hAD); tx_q.push_back(8'hDE);
    bus.send_data = 1'b1;
    step();
    check("tx_active_set", bus.tx_active, 1);
    check("tx_start_not_yet", bus.tx_start, 0);
    step();
    check("tx_start_latency", bus.tx_start, 1);
    repeat (18) step();
    bus.send_data = 1'b0; step();
    bus.tx_word = 32'h12345678;
    bus.send_data = 1'b1; step();
    bus.send_data = 1'b0;
    wait_idle(300);
    repeat (20) step();
    check("tx_count", ntx, 4);
    check("tx_q_empty", tx_q.size(), 0);

    // reset mid-transfer with a partial RX word pending
    send_byte(8'h1B);
    send_byte(8'hAA); send_byte(8'hBB);
    bus.tx_word = 32'h04030201;
    tx_q.push_back(8'h01);
    bus.send_data = 1'b1; step();
    bus.send_data = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_active", bus.tx_active, 0);
    check("rst_mid_tx_start", bus.tx_start, 0);
    check("rst_mid_stop", bus.stop_data, 0);
    check("rst_mid_rx_word", bus.rx_word, 0);
    step(); step();
    rst_n = 1'b1;
    repeat (60) step();
    check("no_tx_after_rst", ntx, 5);
    rx_q.push_back(32'hC4C3C2C1);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    step(); step();
    check("rx_q_empty", rx_q.size(), 0);
    check("tx_q_empty_end", tx_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spart_flag_ctrl.md
# spart_flag_ctrl

SPART-side endpoint of the CPU peripheral flag handshake. Assembles received UART bytes into 32-bit words and raises `received_data` until the CPU acknowledges. Detects the stop command byte and raises `stop_data` until acknowledged. Serializes a CPU-supplied 32-bit word to the UART transmitter when `send_data` is asserted. It sits between the SPART byte-level RX/TX and the CPU peripheral interface.

## Interface
- `STOP_BYTE`, default 8'h1B: command byte that requests playback stop when seen at a word boundary.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `rx_valid` in 1: one-cycle strobe; `rx_byte` is a new received byte.
- `rx_byte` in 8: received byte.
- `received_data` out 1: a full word is available on `rx_word`.
- `rx_word` out 32: the last completed word. Byte 0 is bits [7:0] (little endian).
- `received_ak` in 1: CPU acknowledge of `received_data`. It is a level, held for one or more cycles.
- `stop_data` out 1: stop command pending.
- `stop_ak` in 1: CPU acknowledge of `stop_data`. It is a level.
- `send_data` in 1: CPU request to transmit `tx_word`. It is a level.
- `tx_word` in 32: word to transmit. It is sampled on the `send_data` rising edge.
- `tx_start` out 1: one-cycle strobe to the UART TX; `tx_byte` is valid in that cycle.
- `tx_byte` out 8: byte to transmit.
- `tx_busy` in 1: UART TX is shifting a byte.
- `tx_active` out 1: a word transmission is in progress.
- `overrun` out 1: sticky flag; a completed word was dropped.

## Operation
- Acknowledge and request inputs act on the rising edge only. The block registers the previous value; an edge is `in & ~in_q`. A held level has no further effect.
- RX assembly:
  - A 2-bit `byte_cnt` (0..3) and a 24-bit partial register.
  - On `rx_valid` with `byte_cnt==0` and `rx_byte==STOP_BYTE`: set `stop_data`. The byte is not stored and `byte_cnt` is unchanged.
  - Any other `rx_valid`: store the byte in lane `byte_cnt` and increment `byte_cnt`, wrapping 3→0.
  - On the 4th byte, if `received_data==0`, or a `received_ak` rising edge occurs in the same cycle: load `rx_word` and set `received_data`.
  - Otherwise the word is dropped, `overrun` is set and `rx_word` is unchanged.
- Flag clear:
  - A `received_ak` edge clears `received_data` unless a new word completes in the same cycle; in that case set wins and `rx_word` is updated.
  - A `stop_ak` edge clears `stop_data` and `overrun`. A stop byte arriving in the same cycle wins, so `stop_data` stays 1.
- TX FSM states:
  - `TX_IDLE`: on a `send_data` edge, latch `tx_word`, set `idx` to 0, go to `TX_SEND`.
  - `TX_SEND`: when `tx_busy==0`, pulse `tx_start` with `tx_byte = word[8*idx+:8]`, go to `TX_WAIT_BUSY`.
  - `TX_WAIT_BUSY`: wait for `tx_busy==1`, go to `TX_DRAIN`.
  - `TX_DRAIN`: wait for `tx_busy==0`. If `idx==3` go to `TX_IDLE`; otherwise increment `idx` and go to `TX_SEND`.
- `send_data` edges outside `TX_IDLE` are ignored.
- `tx_active = (state != TX_IDLE)`.

## Timing
- Reset values: all outputs 0; `rx_word` 0; `byte_cnt` 0; state `TX_IDLE`; edge registers 0.
- `received_data` rises the cycle after the 4th `rx_valid`. `stop_data` rises the cycle after the stop byte.
- Flags clear the cycle after the acknowledge edge.
- First `tx_start` is 2 cycles after the `send_data` edge when `tx_busy==0`.
- Bytes go out in the order 0, 1, 2, 3. The next `tx_start` is no earlier than 1 cycle after `tx_busy` falls.
- Reset mid-operation: the partial word and the TX transfer are abandoned. No `tx_start` is issued after reset.

## Configuration
- `SPART_OVERRUN_CNT_EN`:
  - Defined: adds output `overrun_cnt`, 8 bits. It increments on each dropped word, saturates at 8'hFF, resets to 0, and is cleared by a `stop_ak` edge.
  - Undefined: the port and counter are absent. `overrun` is unchanged in either case.

## Structure
- Shared package `spart_pkg`: TX state enum `tx_state_t`, `STOP_BYTE_DEFAULT`, word and byte width constants.
- One sub-module, `rise_edge`: a registered rising-edge detector, instanced for `received_ak`, `stop_ak` and `send_data`.

## Test plan
- Bytes 11, 22, 33, 44 → `received_data`=1 one cycle later; `rx_word`=32'h44332211.
- Hold `received_ak` high 5 cycles → `received_data` clears once. A word completing during the hold stays flagged.
- Two full words without an acknowledge → `overrun`=1; `rx_word` keeps the first word; `overrun_cnt`=1 when enabled.
- 8'h1B at `byte_cnt` 0 → `stop_data`=1. 8'h1B at `byte_cnt` 2 → stored as data. A `stop_ak` edge clears `stop_data` and `overrun`.
- `send_data` with `tx_word`=32'hDEADBEEF, UART model busy 10 cycles per byte → `tx_start` ×4 with bytes EF, BE, AD, DE. A second `send_data` edge mid-transfer is ignored.
- Assert `rst_n`=0 mid-transfer → all outputs 0 immediately; no further `tx_start` after release.
